ssd_scan_ctrl: RTL

//  Display controller for the 4-digit seven-segment readout. Accepts a 13-bit binary value over a

---
 rtl/ssd_scan_ctrl.sv | 96 +++++++++
 1 files changed

// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: converts a 13-bit value to BCD with iterative double-dabble and scans it onto a 4-digit seven-segment display
module ssd_scan_ctrl #(
    parameter int REFRESH_W = 18,
    parameter bit BLANK_LZ  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [12:0] in_value,
    output logic        in_ready,
    output logic        busy,
    output logic [15:0] bcd,
    output logic [7:0]  Anode,
    output logic [6:0]  LED_out
);
    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;
    state_t                state, state_nx;
    logic [12:0]           shift_q;
    logic [15:0]           work_q, adj;
    logic [3:0]            cnt_q, nib;
    logic [REFRESH_W-1:0]  pre_q;
    logic [1:0]            idx_q;
    logic                  blank;
    logic [7:0]            anode_nx;
    logic [6:0]            led_nx;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd1:    seg7 = 7'b1001111;
            4'd2:    seg7 = 7'b0010010;
            4'd3:    seg7 = 7'b0000110;
            4'd4:    seg7 = 7'b1001100;
            4'd5:    seg7 = 7'b0100100;
            4'd6:    seg7 = 7'b0100000;
            4'd7:    seg7 = 7'b0001111;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0000100;
            default: seg7 = 7'b0000001;
        endcase
    endfunction

    assign in_ready = (state == IDLE);
    assign busy     = ~in_ready;

    always_comb begin
        state_nx = (state == IDLE)    ? (in_valid ? CONVERT : IDLE) :
                   (state == CONVERT) ? ((cnt_q == 4'd12) ? COMMIT : CONVERT) : IDLE;
        adj = work_q;
        for (int k = 0; k < 4; k++)
            adj[4*k +: 4] = (work_q[4*k +: 4] >= 4'd5) ? work_q[4*k +: 4] + 4'd3 : work_q[4*k +: 4];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shift_q <= '0;
            work_q  <= '0;
            cnt_q   <= '0;
            bcd     <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && in_valid) begin
                shift_q <= in_value;
                work_q  <= '0;
                cnt_q   <= '0;
            end else if (state == CONVERT) begin
                {work_q, shift_q} <= {adj, shift_q} << 1;
                cnt_q             <= cnt_q + 4'd1;
            end else if (state == COMMIT) begin
                bcd <= work_q;
            end
        end
    end

    // a digit is a leading zero when it and every higher digit are zero
    always_comb begin
        nib      = bcd[{idx_q, 2'b00} +: 4];
        blank    = BLANK_LZ && (idx_q != 2'd0) && ((bcd >> {idx_q, 2'b00}) == 16'd0);
        anode_nx = blank ? 8'hFF : ~(8'b1 << idx_q);
        led_nx   = blank ? 7'b1111111 : seg7(nib);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q   <= '0;
            idx_q   <= '0;
            Anode   <= 8'hFE;
            LED_out <= 7'b0000001;
        end else begin
            pre_q   <= pre_q + 1'b1;
            idx_q   <= (&pre_q) ? idx_q + 2'd1 : idx_q;
            Anode   <= anode_nx;
            LED_out <= led_nx;
        end
    end
endmodule
